// File: rtl/wb_regfile_scoreboard.sv
// Writeback end of the pipeline: architectural register file with write-through reads,
// plus per-register pending-write counters that drive the ID-stage RAW stall.
module wb_regfile_scoreboard #(
  parameter int LEN_DATA     = 32,
  parameter int LEN_INST_REG = 5,
  parameter int PEND_W       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_reg_write,
  input  logic                    wb_mem_to_reg,
  input  logic [LEN_DATA-1:0]     wb_mem_data,
  input  logic [LEN_DATA-1:0]     wb_alu_data,
  input  logic [LEN_INST_REG-1:0] wb_rd,
  input  logic [LEN_INST_REG-1:0] id_rs,
  input  logic [LEN_INST_REG-1:0] id_rt,
  input  logic                    id_use_rs,
  input  logic                    id_use_rt,
  input  logic                    id_issue_valid,
  input  logic [LEN_INST_REG-1:0] id_issue_rd,
  output logic [LEN_DATA-1:0]     rs_data,
  output logic [LEN_DATA-1:0]     rt_data,
  output logic                    stall,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam int NUM_REGS = 2 ** LEN_INST_REG;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [LEN_DATA-1:0] wb_val;
  logic                commit;
  logic                issue;
  logic [LEN_DATA-1:0] rf_word [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] ovf_hit;
  logic [NUM_REGS-1:0] unf_hit;

  assign wb_val = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
  assign commit = wb_reg_write && (wb_rd != '0);
  assign issue  = id_issue_valid && !stall && (id_issue_rd != '0);

  // The register file needs a full clear on reset, so it is built from flops rather than RAM.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rf_word[gi] = '0;
        assign busy[gi]    = 1'b0;
        assign ovf_hit[gi] = 1'b0;
        assign unf_hit[gi] = 1'b0;
      end else begin : g_live
        logic [LEN_DATA-1:0] data_reg;
        logic [PEND_W-1:0]   pend_reg;
        logic                issue_hit;
        logic                retire_hit;

        assign issue_hit  = issue  && (id_issue_rd == LEN_INST_REG'(gi));
        assign retire_hit = commit && (wb_rd       == LEN_INST_REG'(gi));

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            data_reg <= '0;
          end else if (retire_hit) begin
            data_reg <= wb_val;
          end
        end

        // Simultaneous issue and retire to the same register cancel out.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            pend_reg <= '0;
          end else if (issue_hit && !retire_hit) begin
            if (pend_reg != PEND_MAX) pend_reg <= pend_reg + 1'b1;
          end else if (retire_hit && !issue_hit) begin
            if (pend_reg != '0) pend_reg <= pend_reg - 1'b1;
          end
        end

        assign rf_word[gi] = data_reg;
        // A retiring write no longer blocks its readers; the bypass provides the value.
        assign busy[gi]    = (pend_reg != PEND_W'(retire_hit));
        assign ovf_hit[gi] = issue_hit && !retire_hit && (pend_reg == PEND_MAX);
        assign unf_hit[gi] = retire_hit && !issue_hit && (pend_reg == '0);
      end
    end
  endgenerate

  function automatic logic [LEN_DATA-1:0] read_port(input logic [LEN_INST_REG-1:0] idx);
    logic [LEN_DATA-1:0] val;
    val = rf_word[idx];
    if (idx == '0) begin
      val = '0;
    end else if (commit && (idx == wb_rd)) begin
      val = wb_val;
    end
    return val;
  endfunction

  always_comb begin
    rs_data = read_port(id_rs);
    rt_data = read_port(id_rt);
  end

  assign stall = (id_use_rs && busy[id_rs]) || (id_use_rt && busy[id_rt]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (|ovf_hit) err_overflow  <= 1'b1;
      if (|unf_hit) err_underflow <= 1'b1;
    end
  end

endmodule
